// File: rtl/twitchcore_pkg.sv
// Shared twitchcore definitions: datapath width, reset PC and the fetch queue entry.
package twitchcore_pkg;

    localparam int          XLEN     = 32;
    localparam logic [31:0] RESET_PC = 32'h8000_0000;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] insn;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch entries; flush wins over push and pop.
module fetch_fifo
    import twitchcore_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  fetch_entry_t push_data,
    input  logic         pop,
    input  logic         flush,
    output logic [PTR_W:0] count,
    output logic         head_valid,
    output fetch_entry_t head
);

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_pop;

    assign head_valid = (count != '0);
    assign do_pop     = pop && head_valid;
    assign head       = mem[rd_ptr];

    // Storage is reset too so the head reads as all zeros out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !do_pop) begin
                count <= count + 1'b1;
            end else if (do_pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/fetch_queue.sv
// Continuously running instruction prefetch: PC, in-flight tracking and issue control
// in front of a small FIFO toward decode.
module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter int          ADDR_W   = 14,
    parameter logic [31:0] RESET_PC = twitchcore_pkg::RESET_PC
) (
    input  logic              clk,
    input  logic              resetn,
    output logic [ADDR_W-1:0] i_addr,
    output logic              i_req,
    input  logic [31:0]       i_data,
    input  logic              redirect,
    input  logic [31:0]       redirect_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_insn,
    output logic [31:0]       out_pc
);

    import twitchcore_pkg::*;

    localparam int               PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W+1:0] SLOTS = (PTR_W + 2)'(DEPTH);

    logic [31:0]      fetch_pc;
    logic [31:0]      inflight_pc;
    logic             inflight;
    logic [PTR_W:0]   fifo_count;
    logic [PTR_W+1:0] reserved;
    logic [31:0]      redirect_aligned;
    logic             pop;
    logic             push;
    fetch_entry_t     push_entry;
    fetch_entry_t     head;

    assign redirect_aligned = redirect_pc & ~32'h3;
    assign pop              = out_valid && out_ready;
    assign push             = inflight && !redirect;
    assign push_entry       = '{pc: inflight_pc, insn: i_data};

    // The outstanding request already owns a slot, so issuing never overruns the FIFO.
    assign reserved = {1'b0, fifo_count}
                    + {{(PTR_W + 1){1'b0}}, inflight}
                    - {{(PTR_W + 1){1'b0}}, pop};
    assign i_req    = !resetn && !redirect && (reserved < SLOTS);
    assign i_addr   = fetch_pc[ADDR_W-1:0];

    assign out_pc   = head.pc;
    assign out_insn = head.insn;

    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            fetch_pc    <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
        end else if (redirect) begin
            fetch_pc <= redirect_aligned;
            inflight <= 1'b0;
        end else begin
            inflight <= i_req;
            if (i_req) begin
                fetch_pc    <= fetch_pc + 32'd4;
                inflight_pc <= fetch_pc;
            end
        end
    end

    fetch_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (resetn),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .flush     (redirect),
        .count     (fifo_count),
        .head_valid(out_valid),
        .head      (head)
    );

endmodule
